// File: rtl/regwb_pkg.sv
// ============================================================================
// Module   : regwb_pkg
// Purpose  : Shared types and constants for the register-file write-back path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regwb_pkg;

    localparam int ZERO_REG_IDX = 31;
    localparam int REG_COUNT    = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular write-back buffer, up to two enqueues and one dequeue per
//            cycle; exposes all slots and valid bits for lookup logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq0_valid_i,
    input  wb_entry_t                enq0_entry_i,
    input  logic                     enq1_valid_i,
    input  wb_entry_t                enq1_entry_i,
    input  logic                     deq_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     w_wr_ptr1;

    // enq1 is only ever used together with enq0, so it lands in the next slot
    assign w_wr_ptr1 = wr_ptr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (enq0_valid_i) mem_q[wr_ptr_q]  <= enq0_entry_i;
        if (enq1_valid_i) mem_q[w_wr_ptr1] <= enq1_entry_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (deq_i)        valid_q[rd_ptr_q]  <= 1'b0;
            if (enq0_valid_i) valid_q[wr_ptr_q]  <= 1'b1;
            if (enq1_valid_i) valid_q[w_wr_ptr1] <= 1'b1;
            rd_ptr_q <= rd_ptr_q + AW'(deq_i);
            wr_ptr_q <= wr_ptr_q + AW'(enq0_valid_i) + AW'(enq1_valid_i);
            count_q  <= count_q + CW'(enq0_valid_i) + CW'(enq1_valid_i) - CW'(deq_i);
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Merges load and ALU results in program order onto the single
//            register-file write port, with busy scoreboard and optional
//            forwarding (enabled by macro REGWB_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback
    import regwb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BITS     = 64,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [4:0]             ld_rd,
    input  logic [BITS-1:0]        ld_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [4:0]             alu_rd,
    input  logic [BITS-1:0]        alu_data,
    output logic [4:0]             WriteRegister,
    output logic [BITS-1:0]        WriteData,
    output logic                   RegWrite,
    output logic [REG_COUNT-1:0]   busy,
    output logic [$clog2(DEPTH):0] count,
    input  logic [4:0]             fwd_addr1,
    input  logic [4:0]             fwd_addr2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [BITS-1:0]        fwd_data1,
    output logic [BITS-1:0]        fwd_data2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                 RegWrite_q;
    logic [4:0]           WriteRegister_q;
    logic [BITS-1:0]      WriteData_q;

    logic                 w_ready;
    logic                 w_ld_keep;
    logic                 w_alu_keep;
    wb_entry_t            w_ld_entry;
    wb_entry_t            w_alu_entry;
    logic                 w_out_load;
    wb_entry_t            w_out_entry;
    logic                 w_enq0_valid;
    wb_entry_t            w_enq0_entry;
    logic                 w_enq1_valid;
    wb_entry_t            w_enq1_entry;
    logic                 w_deq;
    wb_entry_t            w_head;
    logic [CW-1:0]        w_count;
    wb_entry_t            w_entries [DEPTH];
    logic [DEPTH-1:0]     w_valid;
    logic [AW-1:0]        w_rd_ptr;
    logic [REG_COUNT-1:0] w_busy;

    // Two free slots guarantee room for a worst-case dual enqueue
    assign w_ready   = (w_count <= CW'(DEPTH - 2));
    assign ld_ready  = w_ready;
    assign alu_ready = w_ready;

    assign w_ld_keep   = ld_valid  && w_ready && (ld_rd  != 5'(ZERO_REG));
    assign w_alu_keep  = alu_valid && w_ready && (alu_rd != 5'(ZERO_REG));
    assign w_ld_entry  = '{rd: ld_rd,  data: 64'(ld_data)};
    assign w_alu_entry = '{rd: alu_rd, data: 64'(alu_data)};

    // Age order: FIFO head, then load, then ALU; the rest are enqueued compacted
    always_comb begin
        w_out_load   = 1'b0;
        w_out_entry  = '0;
        w_enq0_valid = 1'b0;
        w_enq0_entry = '0;
        w_enq1_valid = 1'b0;
        w_enq1_entry = '0;
        w_deq        = 1'b0;
        if (w_count != '0) begin
            w_deq       = 1'b1;
            w_out_load  = 1'b1;
            w_out_entry = w_head;
            if (w_ld_keep) begin
                w_enq0_valid = 1'b1;
                w_enq0_entry = w_ld_entry;
                w_enq1_valid = w_alu_keep;
                w_enq1_entry = w_alu_entry;
            end else begin
                w_enq0_valid = w_alu_keep;
                w_enq0_entry = w_alu_entry;
            end
        end else if (w_ld_keep) begin
            w_out_load   = 1'b1;
            w_out_entry  = w_ld_entry;
            w_enq0_valid = w_alu_keep;
            w_enq0_entry = w_alu_entry;
        end else if (w_alu_keep) begin
            w_out_load  = 1'b1;
            w_out_entry = w_alu_entry;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq0_valid_i (w_enq0_valid),
        .enq0_entry_i (w_enq0_entry),
        .enq1_valid_i (w_enq1_valid),
        .enq1_entry_i (w_enq1_entry),
        .deq_i        (w_deq),
        .head_o       (w_head),
        .count_o      (w_count),
        .entries_o    (w_entries),
        .valid_o      (w_valid),
        .rd_ptr_o     (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_q      <= 1'b0;
            WriteRegister_q <= '0;
            WriteData_q     <= '0;
        end else begin
            RegWrite_q <= w_out_load;
            if (w_out_load) begin
                WriteRegister_q <= w_out_entry.rd;
                WriteData_q     <= w_out_entry.data[BITS-1:0];
            end
        end
    end

    assign RegWrite      = RegWrite_q;
    assign WriteRegister = WriteRegister_q;
    assign WriteData     = WriteData_q;
    assign count         = w_count;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_busy[w_entries[i].rd] = 1'b1;
        end
        if (RegWrite_q) w_busy[WriteRegister_q] = 1'b1;
        w_busy[ZERO_REG] = 1'b0;
    end
    assign busy = w_busy;

`ifdef REGWB_FWD_EN
    logic [4:0]      w_fwd_addr [2];
    logic            w_fwd_hit  [2];
    logic [BITS-1:0] w_fwd_data [2];

    assign w_fwd_addr[0] = fwd_addr1;
    assign w_fwd_addr[1] = fwd_addr2;

    // Scan oldest to youngest so the youngest match overwrites earlier ones
    always_comb begin
        logic [AW-1:0] v_idx;
        v_idx = '0;
        for (int p = 0; p < 2; p++) begin
            w_fwd_hit[p]  = 1'b0;
            w_fwd_data[p] = '0;
            if (w_fwd_addr[p] != 5'(ZERO_REG)) begin
                if (RegWrite_q && (WriteRegister_q == w_fwd_addr[p])) begin
                    w_fwd_hit[p]  = 1'b1;
                    w_fwd_data[p] = WriteData_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    v_idx = w_rd_ptr + AW'(i);
                    if (w_valid[v_idx] && (w_entries[v_idx].rd == w_fwd_addr[p])) begin
                        w_fwd_hit[p]  = 1'b1;
                        w_fwd_data[p] = w_entries[v_idx].data[BITS-1:0];
                    end
                end
            end
        end
    end

    assign fwd_hit1  = w_fwd_hit[0];
    assign fwd_hit2  = w_fwd_hit[1];
    assign fwd_data1 = w_fwd_data[0];
    assign fwd_data2 = w_fwd_data[1];
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_addr1, fwd_addr2, w_rd_ptr};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed scoreboard bench for regfile_writeback (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;
    import regwb_pkg::*;

    localparam int DEPTH = 4;
    localparam int BITS  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid, ld_ready, alu_valid, alu_ready;
    logic [4:0]        ld_rd, alu_rd;
    logic [BITS-1:0]   ld_data, alu_data;
    logic [4:0]        WriteRegister;
    logic [BITS-1:0]   WriteData;
    logic              RegWrite;
    logic [31:0]       busy;
    logic [2:0]        count;
    logic [4:0]        fwd_addr1, fwd_addr2;
    logic              fwd_hit1, fwd_hit2;
    logic [BITS-1:0]   fwd_data1, fwd_data2;

    wb_entry_t exp_q [$];
    wb_entry_t mon_e;
    int        n_tests = 0;
    int        n_fail  = 0;
    logic      saw_stall = 1'b0;

`ifdef REGWB_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH), .BITS(BITS), .ZERO_REG(31)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .busy          (busy),
        .count         (count),
        .fwd_addr1     (fwd_addr1),
        .fwd_addr2     (fwd_addr2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && RegWrite) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                         WriteRegister, WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_rd", 64'(WriteRegister), 64'(mon_e.rd));
                check("wb_data", WriteData, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [63:0] adat);
        int tries = 0;
        ld_valid  = lv;  ld_rd  = lrd; ld_data  = ldat;
        alu_valid = av;  alu_rd = ard; alu_data = adat;
        while (!ld_ready && tries < 20) begin
            saw_stall = 1'b1;
            tick();
            tries++;
        end
        if (!ld_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", tries);
        end else begin
            if (lv && lrd != 5'd31) exp_q.push_back('{rd: lrd, data: ldat});
            if (av && ard != 5'd31) exp_q.push_back('{rd: ard, data: adat});
        end
        tick();
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || count != 0) && cyc < 40) begin
            tick();
            cyc++;
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;
        ld_rd = '0; alu_rd = '0; ld_data = '0; alu_data = '0;
        fwd_addr1 = 5'd0; fwd_addr2 = 5'd0;
        tick(); tick();
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_wreg", 64'(WriteRegister), 64'd0);
        check("rst_wdata", WriteData, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fwd_hit", 64'({fwd_hit1, fwd_hit2}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single ALU write: visible one cycle after acceptance, busy only then
        check("pre_busy", 64'(busy), 64'd0);
        send(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hA5);
        check("single_regwrite", 64'(RegWrite), 64'd1);
        check("single_busy", 64'(busy), 64'h20);
        tick();
        check("single_regwrite_off", 64'(RegWrite), 64'd0);
        check("single_busy_off", 64'(busy), 64'd0);

        // Same-rd collision: load first, ALU second
        send(1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22);
        check("coll_count", 64'(count), 64'd1);
        check("coll_busy", 64'(busy), 64'h8);
        tick();
        check("coll_count2", 64'(count), 64'd0);
        check("coll_busy2", 64'(busy), 64'h8);
        tick();
        check("coll_busy3", 64'(busy), 64'd0);

        // Zero register: accepted but discarded
        send(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFF);
        check("zero_count", 64'(count), 64'd0);
        check("zero_regwrite", 64'(RegWrite), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        tick();

        // Back-pressure: 4 back-to-back pairs into a 4-deep FIFO
        for (int i = 0; i < 4; i++)
            send(1'b1, 5'(10 + i), 64'(256 + i), 1'b1, 5'(20 + i), 64'(512 + i));
        check("bp_stalled", 64'(saw_stall), 64'd1);
        drain();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Forwarding: rd7=1 in output stage, rd7=2 in FIFO
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd3;
        send(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2);
        check("fwd_hit1", 64'(fwd_hit1), 64'(FWD));
        check("fwd_data1", fwd_data1, FWD ? 64'h2 : 64'h0);
        check("fwd_hit2_miss", 64'(fwd_hit2), 64'd0);
        tick();
        check("fwd_hit1_outstage", 64'(fwd_hit1), 64'(FWD));
        check("fwd_data1_outstage", fwd_data1, FWD ? 64'h2 : 64'h0);
        fwd_addr2 = 5'd31;
        tick();
        check("fwd_hit1_idle", 64'(fwd_hit1), 64'd0);
        check("fwd_hit2_zero", 64'(fwd_hit2), 64'd0);
        fwd_addr1 = 5'd0;
        fwd_addr2 = 5'd0;

        // Reset while two entries are queued
        send(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
        send(1'b1, 5'd4, 64'h4, 1'b1, 5'd6, 64'h6);
        check("mid_count", 64'(count), 64'd2);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_regwrite", 64'(RegWrite), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_count", 64'(count), 64'd0);

        send(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99);
        check("post_rst_write", 64'(RegWrite), 64'd1);
        drain();
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
